// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, fixed one-cycle-latency imem reads,
// a prefetch FIFO of {word, pc}, and a valid/ready handoff to decode with branch/jump redirect.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  func
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW+1:0] DEPTH_OCC = (PW + 2)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          run;
  logic          inflight;
  logic          drop;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [PW+1:0] occupancy;
  logic          push;
  logic          pop;

  logic [31:0] word_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  // Slots already promised to an outstanding request count as used, so a push never overflows.
  assign occupancy = {1'b0, count} + {{(PW + 1){1'b0}}, inflight};
  assign imem_req  = run & ~flush & (occupancy < DEPTH_OCC);
  assign imem_addr = pc;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  assign push        = inflight & ~drop & ~flush;

  assign instr    = instr_valid ? word_mem[rd_ptr] : 32'h0;
  assign instr_pc = instr_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign opcode   = instr[31:26];
  assign func     = instr[5:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      run      <= 1'b0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        // Redirect wins over everything; the pending response is marked for discard.
        pc       <= flush_pc & 32'hFFFF_FFFC;
        inflight <= 1'b0;
        drop     <= inflight;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        drop <= 1'b0;
        if (imem_req) begin
          pc       <= pc + 32'd4;
          req_pc   <= pc;
          inflight <= 1'b1;
        end else begin
          inflight <= 1'b0;
        end
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

endmodule
